// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame transmitter: FSM states,
// slot kinds and the frame-length/slot-decode functions.
package serial_frame_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  typedef enum logic [2:0] {START, FIELD_A, ZSEP, FIELD_D, PARITY, END} slot_t;

  function automatic int frame_len(input int a_w, input int d_w, input bit parity);
    return a_w + d_w + 4 + (parity ? 1 : 0);
  endfunction

  // Maps a slot index within the frame to what that slot carries.
  function automatic slot_t slot_kind(input int idx, input int a_w, input int d_w,
                                      input bit parity);
    if (idx == 0) return START;
    if (idx <= a_w) return FIELD_A;
    if (idx == a_w + 1) return ZSEP;
    if (idx <= a_w + 1 + d_w) return FIELD_D;
    if (parity && idx == a_w + d_w + 2) return PARITY;
    if (idx == frame_len(a_w, d_w, parity) - 1) return END;
    return ZSEP;
  endfunction

endpackage

// File: rtl/serial_frame_tx_fifo.sv
// Register FIFO holding queued {a,d} words; full/empty are registered flags
// computed from the post-update occupancy.
module serial_frame_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 2
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/serial_frame_tx.sv
// Queued serial frame transmitter: frames 0,A,Z,D,[P],Z,0 with gated clock.
// Optional even-parity slot enabled by SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int A_W       = 7,
  parameter int D_W       = 8,
  parameter int DEPTH     = 2,
  parameter bit LSB_FIRST = 1'b0,
  parameter int IDLE_GAP  = 1
) (
  input  logic           clk_in,
  input  logic           reset_n,
  input  logic           go,
  input  logic [A_W-1:0] a,
  input  logic [D_W-1:0] d,
  output logic           ready,
  output logic           busy,
  output logic           overflow,
  output logic           out_d,
  output logic           out_d_oe,
  output logic           out_c,
  output state_t         fsm_state
);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam int FRAME_LEN = frame_len(A_W, D_W, PARITY_ON);
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam int GW        = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  logic [A_W+D_W-1:0] fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               launch;
  logic               last_slot;
  logic               gap_done;
  logic [A_W-1:0]     a_ord;
  logic [D_W-1:0]     d_ord;
  logic [A_W-1:0]     a_sh;
  logic [D_W-1:0]     d_sh;
  logic               par_q;
  logic [CW-1:0]      cnt;
  logic [GW-1:0]      gap_cnt;
  logic               c_en;

  assign ready = ~fifo_full;
  assign push  = go & ready;

  serial_frame_fifo #(.W(A_W + D_W), .DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .push    (push),
    .pop     (launch),
    .wr_data ({a, d}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Fields are pre-ordered at load so the shifters always emit their MSB.
  always_comb begin
    a_ord = '0;
    d_ord = '0;
    for (int i = 0; i < A_W; i++)
      a_ord[i] = LSB_FIRST ? fifo_rd[D_W + A_W - 1 - i] : fifo_rd[D_W + i];
    for (int i = 0; i < D_W; i++)
      d_ord[i] = LSB_FIRST ? fifo_rd[D_W - 1 - i] : fifo_rd[i];
  end

  assign last_slot = (cnt == CW'(FRAME_LEN - 1));
  assign gap_done  = (gap_cnt == GW'(IDLE_GAP));
  assign launch    = ~fifo_empty &
                     ((fsm_state == IDLE) ||
                      (fsm_state == SHIFT && last_slot && IDLE_GAP == 0) ||
                      (fsm_state == GAP && gap_done));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      fsm_state <= IDLE;
      out_d     <= 1'b1;
      out_d_oe  <= 1'b1;
      c_en      <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      gap_cnt   <= '0;
      a_sh      <= '0;
      d_sh      <= '0;
      par_q     <= 1'b0;
    end else begin
      overflow <= go & ~ready;
      if (launch) begin
        fsm_state <= SHIFT;
        cnt       <= '0;
        out_d     <= 1'b0;
        out_d_oe  <= 1'b1;
        c_en      <= 1'b1;
        a_sh      <= a_ord;
        d_sh      <= d_ord;
        par_q     <= ^fifo_rd;
        busy      <= 1'b1;
      end else begin
        unique case (fsm_state)
          IDLE: begin
            out_d    <= 1'b1;
            out_d_oe <= 1'b1;
            c_en     <= 1'b0;
            busy     <= push;
          end
          SHIFT: begin
            if (last_slot) begin
              out_d    <= 1'b1;
              out_d_oe <= 1'b1;
              c_en     <= 1'b0;
              if (IDLE_GAP > 0) begin
                fsm_state <= GAP;
                gap_cnt   <= GW'(1);
                busy      <= 1'b1;
              end else begin
                fsm_state <= IDLE;
                busy      <= push;
              end
            end else begin
              cnt  <= cnt + 1'b1;
              busy <= 1'b1;
              unique case (slot_kind(int'(cnt) + 1, A_W, D_W, PARITY_ON))
                FIELD_A: begin
                  out_d    <= a_sh[A_W-1];
                  out_d_oe <= 1'b1;
                  a_sh     <= a_sh << 1;
                end
                FIELD_D: begin
                  out_d    <= d_sh[D_W-1];
                  out_d_oe <= 1'b1;
                  d_sh     <= d_sh << 1;
                end
                ZSEP: begin
                  out_d    <= 1'b1;
                  out_d_oe <= 1'b0;
                end
                PARITY: begin
                  out_d    <= par_q;
                  out_d_oe <= 1'b1;
                end
                END: begin
                  out_d    <= 1'b0;
                  out_d_oe <= 1'b1;
                end
                default: begin
                  out_d    <= 1'b1;
                  out_d_oe <= 1'b1;
                end
              endcase
            end
          end
          GAP: begin
            if (gap_done) begin
              fsm_state <= IDLE;
              busy      <= push;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
              busy    <= 1'b1;
            end
          end
          default: fsm_state <= IDLE;
        endcase
      end
    end
  end

  // Low while clk_in is high in a frame slot: falls at the rising edge.
  assign out_c = ~(clk_in & c_en);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: u0 is MSB-first with a one-cycle gap,
// u1 is LSB-first with no gap. Parity frames checked under SERIAL_FRAME_TX_PARITY_EN.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int FL = 20;
`else
  localparam int FL = 19;
`endif

  logic clk_in = 1'b0;
  logic reset_n = 1'b0;
  logic go0 = 1'b0, go1 = 1'b0;
  logic [6:0] a0 = '0, a1 = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic rdy0, busy0, ovf0, od0, oe0, oc0;
  logic rdy1, busy1, ovf1, od1, oe1, oc1;
  state_t st0, st1;

  int total = 0;
  int bad = 0;
  logic [14:0] exp_q[$];

  serial_frame_tx #(.A_W(7), .D_W(8), .DEPTH(2), .LSB_FIRST(1'b0), .IDLE_GAP(1)) u0 (
    .clk_in(clk_in), .reset_n(reset_n), .go(go0), .a(a0), .d(d0),
    .ready(rdy0), .busy(busy0), .overflow(ovf0), .out_d(od0), .out_d_oe(oe0),
    .out_c(oc0), .fsm_state(st0)
  );

  serial_frame_tx #(.A_W(7), .D_W(8), .DEPTH(2), .LSB_FIRST(1'b1), .IDLE_GAP(0)) u1 (
    .clk_in(clk_in), .reset_n(reset_n), .go(go1), .a(a1), .d(d1),
    .ready(rdy1), .busy(busy1), .overflow(ovf1), .out_d(od1), .out_d_oe(oe1),
    .out_c(oc1), .fsm_state(st1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- helpers ----------------
  function automatic logic g_d(input int s);   return s ? od1 : od0;     endfunction
  function automatic logic g_oe(input int s);  return s ? oe1 : oe0;     endfunction
  function automatic logic g_c(input int s);   return s ? oc1 : oc0;     endfunction
  function automatic logic g_rdy(input int s); return s ? rdy1 : rdy0;   endfunction
  function automatic logic g_bsy(input int s); return s ? busy1 : busy0; endfunction
  function automatic logic g_ovf(input int s); return s ? ovf1 : ovf0;   endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int s, input logic g, input logic [6:0] av, input logic [7:0] dv);
    if (s == 0) begin go0 = g; a0 = av; d0 = dv; end
    else        begin go1 = g; a1 = av; d1 = dv; end
  endtask

  task automatic send(input int s, input logic [6:0] av, input logic [7:0] dv);
    drive(s, 1'b1, av, dv);
    step();
    drive(s, 1'b0, ~av, ~dv);
  endtask

  // Reference frame: slot i at bit i; unused high bits stay 1.
  task automatic build(input logic [6:0] av, input logic [7:0] dv, input bit lsb,
                       output logic [19:0] ed, output logic [19:0] eoe);
    int p;
    ed = '1; eoe = '1; p = 0;
    ed[p] = 1'b0; p++;
    for (int i = 0; i < 7; i++) begin ed[p] = lsb ? av[i] : av[6-i]; p++; end
    eoe[p] = 1'b0; p++;
    for (int i = 0; i < 8; i++) begin ed[p] = lsb ? dv[i] : dv[7-i]; p++; end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    ed[p] = ^{av, dv}; p++;
`endif
    eoe[p] = 1'b0; p++;
    ed[p] = 1'b0;
  endtask

  task automatic wait_start(input int s, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (g_d(s) === 1'b0 && g_oe(s) === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Called at the sample point of a start slot; returns at the end slot.
  task automatic check_frame(input int s, input logic [6:0] av, input logic [7:0] dv,
                             input bit lsb, input string name);
    logic [19:0] ed, eoe, gd, goe;
    logic clk_ok;
    build(av, dv, lsb, ed, eoe);
    gd = '1; goe = '1; clk_ok = 1'b1;
    for (int i = 0; i < FL; i++) begin
      gd[i] = g_d(s);
      goe[i] = g_oe(s);
      if (g_c(s) !== 1'b0) clk_ok = 1'b0;
      if (i < FL - 1) step();
    end
    total++;
    if (gd !== ed) begin
      bad++;
      $display("FAIL %s data: got %b want %b", name, gd, ed);
    end
    total++;
    if (goe !== eoe) begin
      bad++;
      $display("FAIL %s oe: got %b want %b", name, goe, eoe);
    end
    total++;
    if (clk_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s out_c pulses: got not low in every slot want low in all %0d", name, FL);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    total++;
    if ({od0, oe0, oc0, rdy0, busy0, ovf0} !== 6'b111100) begin
      bad++;
      $display("FAIL reset_u0: got %b want 111100", {od0, oe0, oc0, rdy0, busy0, ovf0});
    end
    total++;
    if ({od1, oe1, oc1, rdy1, busy1, ovf1} !== 6'b111100) begin
      bad++;
      $display("FAIL reset_u1: got %b want 111100", {od1, oe1, oc1, rdy1, busy1, ovf1});
    end
    @(negedge clk_in);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    send(0, 7'b1000001, 8'b10000001);
    step();
    total++;
    if ({od0, oe0} !== 2'b01) begin
      bad++;
      $display("FAIL latency: got d/oe %b want 01", {od0, oe0});
    end
    check_frame(0, 7'b1000001, 8'b10000001, 1'b0, "single_msb");
    step();
    total++;
    if ({od0, oe0, oc0} !== 3'b111) begin
      bad++;
      $display("FAIL idle_after: got %b want 111", {od0, oe0, oc0});
    end
    step();
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL busy_after: got %b want 0", busy0);
    end
  endtask

  task automatic test_lsb(input logic [6:0] av, input logic [7:0] dv, input string name);
    bit found;
    send(1, av, dv);
    wait_start(1, 4, found);
    total++;
    if (found !== 1'b1) begin
      bad++;
      $display("FAIL %s start: got none want start within 4 cycles", name);
    end
    check_frame(1, av, dv, 1'b1, name);
    step();
  endtask

  // n go pulses on consecutive cycles; n_acc words are expected to be accepted.
  task automatic test_back_to_back(input int s, input int n, input int n_acc,
                                   input int exp_ov, input int gap, input bit lsb,
                                   input string name);
    int ov_seen;
    logic rdy_end;
    bit found;
    int gap_bad;
    logic [14:0] w;
    ov_seen = 0;
    gap_bad = 0;
    exp_q.delete();
    for (int i = 0; i < n_acc; i++)
      exp_q.push_back({7'(7'h15 + 7'(i * 9)), 8'(8'h3C ^ 8'(i * 8'h21))});
    fork
      begin
        for (int i = 0; i < n; i++) begin
          drive(s, 1'b1, 7'(7'h15 + 7'(i * 9)), 8'(8'h3C ^ 8'(i * 8'h21)));
          step();
          if (g_ovf(s) === 1'b1) ov_seen++;
        end
        rdy_end = g_rdy(s);
        drive(s, 1'b0, '0, '0);
      end
      begin
        wait_start(s, 4, found);
        total++;
        if (found !== 1'b1) begin
          bad++;
          $display("FAIL %s first_start: got none want start", name);
        end
        for (int j = 0; j < n_acc; j++) begin
          w = exp_q.pop_front();
          if (j > 0) begin
            for (int g = 0; g < gap; g++) begin
              step();
              if ({g_d(s), g_c(s)} !== 2'b11) gap_bad++;
            end
            step();
            if (g_d(s) !== 1'b0) gap_bad++;
          end
          check_frame(s, w[14:8], w[7:0], lsb, name);
        end
        step();
        wait_start(s, 60, found);
        total++;
        if (found !== 1'b0) begin
          bad++;
          $display("FAIL %s no_extra: got extra frame want none", name);
        end
      end
    join
    total++;
    if (gap_bad !== 0) begin
      bad++;
      $display("FAIL %s gap: got %0d bad gap cycles want 0", name, gap_bad);
    end
    total++;
    if (ov_seen !== exp_ov) begin
      bad++;
      $display("FAIL %s overflow: got %0d want %0d", name, ov_seen, exp_ov);
    end
    total++;
    if (rdy_end !== 1'b0) begin
      bad++;
      $display("FAIL %s ready_full: got %b want 0", name, rdy_end);
    end
    total++;
    if ({g_bsy(s), g_rdy(s)} !== 2'b01) begin
      bad++;
      $display("FAIL %s drained: got busy/ready %b want 01", name, {g_bsy(s), g_rdy(s)});
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    send(0, 7'h55, 8'hAA);
    send(0, 7'h2A, 8'h0F);
    repeat (3) step();
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({od0, oe0, oc0} !== 3'b111) begin
      bad++;
      $display("FAIL reset_mid_async: got %b want 111", {od0, oe0, oc0});
    end
    @(negedge clk_in);
    reset_n = 1'b1;
    step();
    total++;
    if ({rdy0, busy0} !== 2'b10) begin
      bad++;
      $display("FAIL reset_mid_queue: got ready/busy %b want 10", {rdy0, busy0});
    end
    wait_start(0, 60, found);
    total++;
    if (found !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_nosend: got frame want none");
    end
  endtask

`ifdef SERIAL_FRAME_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] dv, input string name);
    bit found;
    send(0, 7'h7F, dv);
    wait_start(0, 4, found);
    total++;
    if (found !== 1'b1) begin
      bad++;
      $display("FAIL %s start: got none want start", name);
    end
    check_frame(0, 7'h7F, dv, 1'b0, name);
    repeat (3) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_lsb(7'b1000001, 8'b10000001, "lsb_pal");
    test_lsb(7'h01, 8'h80, "lsb_0180");
    test_back_to_back(0, 3, 3, 0, 1, 1'b0, "three_gap1");
    test_back_to_back(0, 5, 3, 2, 1, 1'b0, "five_ovf");
    test_back_to_back(1, 3, 3, 0, 0, 1'b1, "three_gap0");
    test_reset_mid();
`ifdef SERIAL_FRAME_TX_PARITY_EN
    test_parity(8'h01, "parity_0");
    test_parity(8'h00, "parity_1");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Parametrised parallel-in/serial-out frame transmitter with a gated forwarded clock. It queues up to DEPTH {A, D} words and serialises each one as the frame 0, A, Z, D, Z, 0. Frames are sent back-to-back with a programmable idle gap. It replaces the fixed 7/8-bit single-shot buffer on the off-chip serial link and adds queuing, bit order selection, a ready/overflow handshake and an explicit output-enable for the Z slots.

Parameters:
A_W, 7, address field width (>=1)
D_W, 8, data field width (>=1)
DEPTH, 2, frame queue depth in entries (>=1, power of 2 not required)
LSB_FIRST, 0, 0 = fields sent MSB first; 1 = LSB first
IDLE_GAP, 1, minimum idle cycles (out_d=1) between the end bit of one frame and the start bit of the next (>=0)

Ports:
clk_in  in  1  clock; all state changes on rising edge
reset_n  in  1  reset; asynchronous, active-low
go  in  1  single-cycle request to queue {a,d}
a  in  A_W  address field, sampled when go=1 and ready=1
d  in  D_W  data field, sampled when go=1 and ready=1
ready  out  1  registered; 1 = queue not full
busy  out  1  registered; 1 = frame in flight, gap counting, or queue non-empty
overflow  out  1  registered; one-cycle pulse when go=1 and ready=0
out_d  out  1  serial data, registered
out_d_oe  out  1  registered; 0 during the two Z slots; the pad drives Z when this is 0
out_c  out  1  forwarded clock = ~(clk_in & c_en); c_en is a registered enable

Behaviour:
- Reset (async): queue emptied, FSM=IDLE, out_d=1, out_d_oe=1, c_en=0, out_c=1, ready=1, busy=0, overflow=0. A reset mid-frame aborts the frame immediately and discards all queued entries.
- Frame: FRAME_LEN = A_W + D_W + 4 slots, in this order: start 0, A bits, Z slot (out_d_oe=0, out_d=1), D bits, Z slot, end 0.
- Bit order: LSB_FIRST selects the order within each field. Field order is always A then D.
- Timing: one slot per clk_in cycle; out_d and out_d_oe update on the rising edge. out_c falls at the rising edge and rises at the falling edge, so the receiver samples on posedge out_c, mid-bit.
- c_en is 1 exactly during frame slots, so out_c pulses once per slot and stays 1 during idle and gap cycles.
- Enqueue: if go=1 and ready=1 at edge k, the entry is written at k. ready for cycle k+1 reflects occupancy after both the write and any pop at k. go while ready=0 drops the word and pulses overflow for one cycle.
- A pop in the same cycle does not make a full queue accept go; ready is registered.
- FSM states:
  - IDLE: out_d=1, oe=1, c_en=0. If the queue is non-empty at edge k, pop the head, load the shifter and counter, drive the start 0, set c_en, go to SHIFT.
  - Latency: go on an empty, idle block at edge k puts the start bit on out_d after edge k+1.
  - SHIFT: counter walks 0..FRAME_LEN-1; after the end slot, go to GAP (or to IDLE/next frame if IDLE_GAP=0).
  - GAP: out_d=1, c_en=0 for IDLE_GAP cycles, then IDLE.
  - With IDLE_GAP=0 and a non-empty queue, the next start bit directly follows the end bit.
- Counter width: $clog2(FRAME_LEN+1). Queue pointers wrap modulo DEPTH; a full/empty flag or occupancy count disambiguates when pointers are equal.
- a/d changing after acceptance has no effect on queued or in-flight frames.

Optional Feature:
Macro SERIAL_FRAME_TX_PARITY_EN.
- Defined: an even-parity bit over A and D is inserted between the last D bit and the second Z slot; FRAME_LEN = A_W + D_W + 5.
- Undefined: no parity slot; frame exactly as above.

Decomposition:
- Package serial_frame_pkg holds:
  - FSM state enum {IDLE, SHIFT, GAP}
  - a FRAME_LEN function of (A_W, D_W, parity)
  - slot-kind constants START, FIELD_A, ZSEP, FIELD_D, PARITY, END
- One sub-module, serial_frame_fifo: DEPTH x (A_W+D_W) register FIFO with push/pop/full/empty. The FSM and shifter stay in the top module.

Test Plan:
- Reset, then go with a=7'b1000001, d=8'b10000001, LSB_FIRST=0 -> start bit at cycle k+1. Sequence 0,1000001,Z,10000001,Z,0 over 19 out_c pulses. Then out_d=1, out_c=1, busy=0.
- Same data with LSB_FIRST=1 -> A field 1000001 and D field 10000001 (palindromes). Repeat with a=7'h01, d=8'h80 -> A sent 1000000, D sent 00000001.
- DEPTH=2, IDLE_GAP=1: three go pulses on consecutive cycles -> all accepted (first popped at once). Three frames, each separated by exactly one idle cycle. overflow stays 0.
- DEPTH=2: five go pulses on consecutive cycles -> overflow pulses for each rejected go. Only accepted frames appear, in order, with contents matching the queued words.
- Reset_n low mid-A-field -> out_d=1, out_d_oe=1, out_c=1 asynchronously. Queue is empty after release and no further frames are sent.
- PARITY_EN, a=7'h7F, d=8'h01 -> parity slot=0 (eight ones) and 20-slot frame. With d=8'h00 -> parity=1.
